control_flujo_fifos: RTL
========================

Name: control_flujo_fifos

Overview:
- Occupancy and flow-control tracker for the 8 data FIFOs of the switch datapath.
- Sits at the opposite end of the threshold/empty interface from the main control state machine:
  - consumes the low/high thresholds (bajo/alto) that the state machine publishes while in IDLE;
  - produces the per-FIFO empty vector that the state machine uses for its IDLE/ACTIVE decision.
- Tracks each FIFO's fill count from push/pop strobes and raises a hysteretic pause (pausa) toward the upstream source.

Parameters:
- NUM_FIFOS, 8, number of FIFOs tracked (one bit per FIFO in every vector port).
- DEPTH, 8, FIFO capacity in words; count range 0..DEPTH.
- CNT_W, 4, count width; must hold DEPTH.
- ALTO_RST, 3'd6, high threshold after reset.
- BAJO_RST, 3'd2, low threshold after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- idle_in  in  1  state machine is in IDLE; alto_in/bajo_in valid.
- alto_in  in  3  high threshold from state machine.
- bajo_in  in  3  low threshold from state machine.
- push  in  NUM_FIFOS  per-FIFO write strobe.
- pop  in  NUM_FIFOS  per-FIFO read strobe.
- empty_fifos  out  NUM_FIFOS  count==0 per FIFO; feeds state machine.
- full_fifos  out  NUM_FIFOS  count==DEPTH per FIFO.
- almost_full  out  NUM_FIFOS  count >= alto_q per FIFO.
- almost_empty  out  NUM_FIFOS  count <= bajo_q per FIFO.
- pausa  out  1  flow-control pause to upstream.
- error  out  NUM_FIFOS  sticky overflow/underflow flag per FIFO.
- umbral_invalido  out  1  last threshold load attempt rejected.

Behaviour:
Reset (reset=0, asynchronous):
- All counts = 0.
- alto_q = ALTO_RST, bajo_q = BAJO_RST.
- pausa = 0, error = 0, umbral_invalido = 0, FSM = NORMAL.
- Derived outputs: empty_fifos = all 1s, full_fifos = 0, almost_full = 0, almost_empty = all 1s.
- Reset mid-operation discards all counts and flags immediately; no clock edge is required.

Counters (per FIFO, each rising edge):
- push only, not full: +1.
- pop only, not empty: -1.
- push and pop, count between 1 and DEPTH-1: unchanged.
- push and pop when empty: pop ignored, +1.
- push and pop when full: push ignored, -1.
- push when full (alone): count holds, error bit set.
- pop when empty (alone): count holds, error bit set.
- Counts never wrap.
- error is sticky until reset.

Flags:
- empty_fifos, full_fifos, almost_full and almost_empty are combinational decodes of the registered counts and registered thresholds.
- They therefore change in the cycle immediately after the edge that updated the count.
- Comparisons are unsigned; the 3-bit thresholds are zero-extended to CNT_W.

Threshold load:
- On a rising edge with idle_in=1:
  - if bajo_in < alto_in: alto_q <= alto_in, bajo_q <= bajo_in, umbral_invalido <= 0;
  - otherwise: thresholds hold, umbral_invalido <= 1.
- With idle_in=0: thresholds and umbral_invalido hold.
- New thresholds affect the flags in the cycle after the load edge.

Pause FSM (states NORMAL, PAUSA; pausa=1 only in PAUSA; state registered):
- NORMAL -> PAUSA when any almost_full bit = 1.
- PAUSA -> NORMAL when every almost_empty bit = 1.
- Otherwise the state holds (hysteresis band between bajo_q and alto_q).
- pausa asserts or deasserts one edge after the condition is first visible on the flags.
- A threshold change that satisfies both conditions at once: PAUSA has priority (enter or stay in PAUSA).

Test Plan:
- Reset release, no traffic -> empty_fifos=8'hFF, almost_empty=8'hFF, pausa=0, error=0, alto_q=6, bajo_q=2.
- Six pushes to FIFO 3 -> count 6, almost_full[3]=1 after the 6th edge, pausa=1 one edge later; pop 3 -> count 3, pausa stays 1; pop 1 more -> count 2, pausa=0 one edge later.
- Eight pushes to FIFO 0, then push alone -> full_fifos[0]=1, count stays 8, error[0]=1; simultaneous push+pop at full -> count 7; error[0] stays 1 until reset.
- Simultaneous push+pop on empty FIFO 5 -> count 1, error[5]=0; pop alone on empty FIFO 6 -> count 0, error[6]=1.
- idle_in=1 with alto_in=4, bajo_in=1 -> loaded, umbral_invalido=0; then idle_in=1 with alto_in=2, bajo_in=5 -> thresholds remain 4/1, umbral_invalido=1; idle_in=0 with a valid pair -> ignored.
- FIFO 2 at count 5 with pausa=1, then reset pulsed low for less than one clock period -> all outputs return to reset values with no clock edge; empty_fifos=8'hFF.

Source files
------------

// File: rtl/control_flujo_fifos_if.sv
// Threshold/empty and push/pop/flag bundle between the switch control logic and
// the FIFO occupancy tracker.
interface control_flujo_fifos_if #(
  parameter int NUM_FIFOS = 8
);
  logic                 idle_in;
  logic [2:0]           alto_in;
  logic [2:0]           bajo_in;
  logic [NUM_FIFOS-1:0] push;
  logic [NUM_FIFOS-1:0] pop;
  logic [NUM_FIFOS-1:0] empty_fifos;
  logic [NUM_FIFOS-1:0] full_fifos;
  logic [NUM_FIFOS-1:0] almost_full;
  logic [NUM_FIFOS-1:0] almost_empty;
  logic                 pausa;
  logic [NUM_FIFOS-1:0] error;
  logic                 umbral_invalido;

  modport master (
    output idle_in, alto_in, bajo_in, push, pop,
    input  empty_fifos, full_fifos, almost_full, almost_empty, pausa, error,
           umbral_invalido
  );

  modport slave (
    input  idle_in, alto_in, bajo_in, push, pop,
    output empty_fifos, full_fifos, almost_full, almost_empty, pausa, error,
           umbral_invalido
  );
endinterface

// File: rtl/control_flujo_fifos.sv
// Per-FIFO fill counters, threshold-based flags and a hysteretic pause toward
// the upstream source; thresholds are accepted only while the controller idles.
module control_flujo_fifos #(
  parameter int         NUM_FIFOS = 8,
  parameter int         DEPTH     = 8,
  parameter int         CNT_W     = 4,
  parameter logic [2:0] ALTO_RST  = 3'd6,
  parameter logic [2:0] BAJO_RST  = 3'd2
) (
  input  logic                  clk,
  input  logic                  reset,
  control_flujo_fifos_if.slave  bus
);

  typedef enum logic {NORMAL, PAUSA} estado_e;

  logic [CNT_W-1:0]     count_q [NUM_FIFOS];
  logic [CNT_W-1:0]     count_d [NUM_FIFOS];
  logic [NUM_FIFOS-1:0] error_q, error_d;
  logic [2:0]           alto_q, alto_d;
  logic [2:0]           bajo_q, bajo_d;
  logic                 umbral_q, umbral_d;
  estado_e              estado_q, estado_d;

  logic [NUM_FIFOS-1:0] empty_v, full_v, afull_v, aempty_v;
  logic                 pausa_v;

  // Flag decode from registered counts and thresholds only.
  always_comb begin
    for (int i = 0; i < NUM_FIFOS; i++) begin
      empty_v[i]  = (count_q[i] == '0);
      full_v[i]   = (count_q[i] == CNT_W'(DEPTH));
      afull_v[i]  = (count_q[i] >= CNT_W'(alto_q));
      aempty_v[i] = (count_q[i] <= CNT_W'(bajo_q));
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_FIFOS; i++) begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      count_d[i] = count_q[i];
      error_d[i] = error_q[i];
      unique case ({bus.push[i], bus.pop[i]})
        2'b10: if (full_v[i])  error_d[i] = 1'b1;
               else            count_d[i] = count_q[i] + CNT_W'(1);
        2'b01: if (empty_v[i]) error_d[i] = 1'b1;
               else            count_d[i] = count_q[i] - CNT_W'(1);
        2'b11: if (empty_v[i])     count_d[i] = count_q[i] + CNT_W'(1);
               else if (full_v[i]) count_d[i] = count_q[i] - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    alto_d   = alto_q;
    bajo_d   = bajo_q;
    umbral_d = umbral_q;
    if (bus.idle_in) begin
      if (bus.bajo_in < bus.alto_in) begin
        alto_d   = bus.alto_in;
        bajo_d   = bus.bajo_in;
        umbral_d = 1'b0;
      end else begin
        umbral_d = 1'b1;
      end
    end
  end

  // Entering/holding PAUSA wins when a threshold change satisfies both exits.
  always_comb begin
    estado_d = estado_q;
    if (|afull_v)
      estado_d = PAUSA;
    else if (estado_q == PAUSA && &aempty_v)
      estado_d = NORMAL;
  end

  always_comb begin
    pausa_v = (estado_q == PAUSA);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: counters are control state, not data storage, so every entry is reset.
      for (int i = 0; i < NUM_FIFOS; i++) count_q[i] <= '0;
      error_q  <= '0;
      alto_q   <= ALTO_RST;
      bajo_q   <= BAJO_RST;
      umbral_q <= 1'b0;
      estado_q <= NORMAL;
    end else begin
      // NOTE: registers use non-blocking assignment so all flops sample pre-edge values.
      for (int i = 0; i < NUM_FIFOS; i++) count_q[i] <= count_d[i];
      error_q  <= error_d;
      alto_q   <= alto_d;
      bajo_q   <= bajo_d;
      umbral_q <= umbral_d;
      estado_q <= estado_d;
    end
  end

  assign bus.empty_fifos     = empty_v;
  assign bus.full_fifos      = full_v;
  assign bus.almost_full     = afull_v;
  assign bus.almost_empty    = aempty_v;
  assign bus.pausa           = pausa_v;
  assign bus.error           = error_q;
  assign bus.umbral_invalido = umbral_q;

endmodule
